// File: rtl/match_sequencer.sv
// Match-level sequencer for a two-player reaction game: arms each round, tallies
// round wins and consecutive ties, paces the gap between rounds and declares the result.
module match_sequencer #(
  parameter int WINS_NEEDED = 3,
  parameter int PAUSE_TICKS = 4,
  parameter int TIE_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       winrnd,
  input  logic       right,
  input  logic       tie,
  input  logic       slowen,
  output logic       round_en,
  output logic       clear,
  output logic [2:0] wins_l,
  output logic [2:0] wins_r,
  output logic       match_over,
  output logic       winner_right,
  output logic       draw
);

  localparam logic [2:0] WINS_TGT   = 3'(WINS_NEEDED);
  localparam logic [2:0] TIE_TGT    = 3'(TIE_LIMIT);
  localparam logic [3:0] PAUSE_LOAD = 4'(PAUSE_TICKS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] wins_l_reg, wins_l_next;
  logic [2:0] wins_r_reg, wins_r_next;
  logic [2:0] tie_cnt_reg, tie_cnt_next;
  logic [3:0] pause_cnt_reg, pause_cnt_next;
  logic       winner_right_reg, winner_right_next;
  logic       draw_reg, draw_next;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  always_comb begin
    state_next        = state_reg;
    wins_l_next       = wins_l_reg;
    wins_r_next       = wins_r_reg;
    tie_cnt_next      = tie_cnt_reg;
    pause_cnt_next    = pause_cnt_reg;
    winner_right_next = winner_right_reg;
    draw_next         = draw_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          wins_l_next       = 3'd0;
          wins_r_next       = 3'd0;
          tie_cnt_next      = 3'd0;
          winner_right_next = 1'b0;
          draw_next         = 1'b0;
          state_next        = ARM;
        end
      end
      ARM: state_next = PLAY;
      PLAY: begin
        if (winrnd) begin
          if (tie) begin
            tie_cnt_next = sat_inc(tie_cnt_reg);
          end else begin
            tie_cnt_next = 3'd0;
            if (right) wins_r_next = sat_inc(wins_r_reg);
            else       wins_l_next = sat_inc(wins_l_reg);
          end
          state_next = SCORE;
        end
      end
      SCORE: begin
        // Right win outranks left win, which outranks the tie limit.
        if (wins_r_reg == WINS_TGT) begin
          winner_right_next = 1'b1;
          draw_next         = 1'b0;
          state_next        = DONE;
        end else if (wins_l_reg == WINS_TGT) begin
          winner_right_next = 1'b0;
          draw_next         = 1'b0;
          state_next        = DONE;
        end else if (tie_cnt_reg == TIE_TGT) begin
          winner_right_next = 1'b0;
          draw_next         = 1'b1;
          state_next        = DONE;
        end else begin
          pause_cnt_next = PAUSE_LOAD;
          state_next     = PAUSE;
        end
      end
      PAUSE: begin
        if (slowen) begin
          if (pause_cnt_reg <= 4'd1) begin
            pause_cnt_next = 4'd0;
            state_next     = ARM;
          end else begin
            pause_cnt_next = pause_cnt_reg - 4'd1;
          end
        end
      end
      default: begin
        wins_l_next       = 3'd0;
        wins_r_next       = 3'd0;
        tie_cnt_next      = 3'd0;
        pause_cnt_next    = 4'd0;
        winner_right_next = 1'b0;
        draw_next         = 1'b0;
        state_next        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      wins_l_reg       <= 3'd0;
      wins_r_reg       <= 3'd0;
      tie_cnt_reg      <= 3'd0;
      pause_cnt_reg    <= 4'd0;
      winner_right_reg <= 1'b0;
      draw_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wins_l_reg       <= wins_l_next;
      wins_r_reg       <= wins_r_next;
      tie_cnt_reg      <= tie_cnt_next;
      pause_cnt_reg    <= pause_cnt_next;
      winner_right_reg <= winner_right_next;
      draw_reg         <= draw_next;
    end
  end

  // Every output comes straight from a register or a state decode.
  assign round_en     = (state_reg == PLAY);
  assign clear        = (state_reg == ARM);
  assign match_over   = (state_reg == DONE);
  assign wins_l       = wins_l_reg;
  assign wins_r       = wins_r_reg;
  assign winner_right = winner_right_reg;
  assign draw         = draw_reg;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized scoreboard bench for match_sequencer: a match-level reference model
// queues expected round tallies and match results, and a monitor checks them.
module tb_match_sequencer;
  localparam int WN = 3;
  localparam int PT = 4;
  localparam int TL = 3;

  logic       clk = 1'b0;
  logic       rst, start, winrnd, right, tie, slowen;
  logic       round_en, clear, match_over, winner_right, draw;
  logic [2:0] wins_l, wins_r;

  always #5 clk = ~clk;

  match_sequencer #(.WINS_NEEDED(WN), .PAUSE_TICKS(PT), .TIE_LIMIT(TL)) dut (
    .clk(clk), .rst(rst), .start(start), .winrnd(winrnd), .right(right),
    .tie(tie), .slowen(slowen), .round_en(round_en), .clear(clear),
    .wins_l(wins_l), .wins_r(wins_r), .match_over(match_over),
    .winner_right(winner_right), .draw(draw)
  );

  int compared = 0;
  int mismatched = 0;
  int slow_period = 8;
  int slow_cnt = 0;
  bit mon_en = 1'b0;
  int clear_total = 0;
  int clear_base = 0;
  int exp_round[$];
  int exp_result[$];

  // Reference model state: counts of the current match.
  int m_wl, m_wr, m_ties, m_rounds, m_result;
  bit m_over;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pacing tick generator, changed on the falling edge.
  initial begin
    slowen = 1'b0;
    forever begin
      @(negedge clk);
      slow_cnt++;
      if (slow_cnt >= slow_period) begin
        slow_cnt = 0;
        slowen = 1'b1;
      end else begin
        slowen = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when the DUT ends a round or a match.
  initial begin
    bit p_ren, p_rst, p_mo, p_clr;
    int e;
    p_ren = 1'b0; p_rst = 1'b1; p_mo = 1'b0; p_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (clear) begin
          clear_total++;
          check("clear_single_cycle", int'(p_clr), 0);
          check("clear_without_round_en", int'(round_en), 0);
        end
        if (!p_rst && p_ren && !round_en) begin
          if (exp_round.size() == 0) begin
            check("round_unexpected", 1, 0);
          end else begin
            e = exp_round.pop_front();
            check("round_counts", int'({wins_l, wins_r}), e);
          end
        end
        if (!p_rst && match_over && !p_mo) begin
          if (exp_result.size() == 0) begin
            check("result_unexpected", 1, 0);
          end else begin
            e = exp_result.pop_front();
            check("match_result", int'({wins_l, wins_r, winner_right, draw}), e);
          end
        end
      end
      p_ren = round_en; p_rst = rst; p_mo = match_over; p_clr = clear;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_round(input bit t, input bit r);
    if (t) begin
      m_ties = (m_ties < 7) ? m_ties + 1 : 7;
    end else begin
      m_ties = 0;
      if (r) m_wr = (m_wr < 7) ? m_wr + 1 : 7;
      else   m_wl = (m_wl < 7) ? m_wl + 1 : 7;
    end
    exp_round.push_back((m_wl << 3) | m_wr);
    m_over = 1'b1;
    if (m_wr == WN)      m_result = (m_wl << 5) | (m_wr << 2) | 2;
    else if (m_wl == WN) m_result = (m_wl << 5) | (m_wr << 2);
    else if (m_ties == TL) m_result = (m_wl << 5) | (m_wr << 2) | 1;
    else m_over = 1'b0;
    if (m_over) exp_result.push_back(m_result);
  endtask

  task automatic start_match();
    clear_base = clear_total;
    m_wl = 0; m_wr = 0; m_ties = 0; m_rounds = 0; m_over = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_clear", int'(clear), 1);
    check("arm_counts_cleared", int'({wins_l, wins_r, match_over, draw}), 0);
    tick();
    check("play_after_arm", int'(round_en), 1);
  endtask

  task automatic wait_round_en();
    int n = 0;
    while (round_en !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("round_en_timeout", n, 0);
  endtask

  task automatic play_round(input bit t, input bit r, input bit also_start);
    int ticks = 0;
    int n = 0;
    wait_round_en();
    repeat ($urandom_range(0, 3)) tick();
    winrnd = 1'b1; tie = t; right = r; start = also_start;
    tick();
    winrnd = 1'b0; start = 1'b0; tie = 1'($urandom); right = 1'($urandom);
    m_rounds++;
    model_round(t, r);
    check("score_round_en", int'(round_en), 0);
    check("score_match_over", int'(match_over), 0);
    tick();
    check("done_timing", int'(match_over), int'(m_over));
    if (!m_over) begin
      // Stray round-end and start pulses during the pause must be ignored.
      winrnd = 1'($urandom); tie = 1'($urandom); right = 1'($urandom); start = 1'($urandom);
      while (ticks < PT && n < 20 * slow_period + 20) begin
        tick();
        winrnd = 1'b0; start = 1'b0;
        n++;
        if (slowen) ticks++;
        if (ticks < PT && (round_en || clear)) check("pause_early_exit", 1, 0);
      end
      if (ticks < PT) check("pause_timeout", ticks, PT);
      check("arm_after_pause", int'({clear, round_en}), 2);
      check("pause_counts_hold", int'({wins_l, wins_r}), (m_wl << 3) | m_wr);
      tick();
      check("round_en_after_arm", int'({clear, round_en}), 1);
    end
  endtask

  task automatic finish_match();
    check("clear_pulses", clear_total - clear_base, m_rounds);
    repeat (3) begin
      winrnd = 1'($urandom); tie = 1'($urandom); right = 1'($urandom);
      tick();
      winrnd = 1'b0;
      check("done_hold", int'({wins_l, wins_r, winner_right, draw}), m_result);
      check("done_match_over", int'({match_over, round_en, clear}), 4);
    end
  endtask

  task automatic play_random_until_over(input bit allow_start);
    int guard = 0;
    while (!m_over && guard < 60) begin
      play_round(($urandom_range(0, 3) == 0), 1'($urandom),
                 allow_start & 1'($urandom));
      guard++;
    end
    if (!m_over) check("match_never_ended", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) begin
      winrnd = 1'($urandom);
      tick();
      check("idle_outputs",
            int'({round_en, clear, wins_l, wins_r, match_over, winner_right, draw}), 0);
    end
    winrnd = 1'b0;
    check("idle_no_clear", clear_total, 0);

    // Right sweep with slow pacing ticks.
    slow_period = 256;
    start_match();
    repeat (3) play_round(1'b0, 1'b1, 1'b0);
    finish_match();

    // Alternating L R L R L: left takes it 3-2.
    slow_period = 3;
    start_match();
    for (int i = 0; i < 5; i++) play_round(1'b0, (i % 2) == 1, 1'b1);
    finish_match();

    // Three ties in a row end in a draw.
    start_match();
    repeat (3) play_round(1'b1, 1'b0, 1'b0);
    finish_match();

    // A win in between resets the tie run.
    slow_period = 1;
    start_match();
    play_round(1'b1, 1'b0, 1'b0);
    play_round(1'b0, 1'b1, 1'b0);
    play_round(1'b1, 1'b0, 1'b0);
    play_round(1'b1, 1'b0, 1'b0);
    check("tie_run_reset_not_over", int'(m_over), 0);
    play_random_until_over(1'b0);
    finish_match();

    for (int k = 0; k < 4; k++) begin
      slow_period = $urandom_range(1, 6);
      start_match();
      play_random_until_over(1'b1);
      finish_match();
    end

    // Reset in the middle of a round aborts the match.
    start_match();
    play_round(1'b0, 1'b1, 1'b0);
    play_round(1'b0, 1'b1, 1'b0);
    wait_round_en();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_abort",
          int'({round_en, clear, wins_l, wins_r, match_over, winner_right, draw}), 0);
    clear_base = clear_total;
    repeat (5) tick();
    check("no_clear_after_reset", clear_total - clear_base, 0);
    start_match();
    play_random_until_over(1'b0);
    finish_match();

    check("round_queue_drained", exp_round.size(), 0);
    check("result_queue_drained", exp_result.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
